nes_controller_responder: RTL

//   NES controller device side: answers console latch/pulse strobes with serial button data on a single line.

---
 rtl/nes_pkg.sv | 23 ++
 rtl/nes_controller_responder_if.sv | 24 ++
 rtl/nes_sync_edge.sv | 31 +++
 rtl/nes_controller_responder.sv | 111 +++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES controller definitions: FSM states, button bit positions and frame length.
// Used by both the responder (device side) and the Pong controller reader.
package nes_pkg;

   localparam int NES_BITS  = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LATCHED  = 2'd1,
      SHIFTING = 2'd2,
      DONE     = 2'd3
   } nes_state_t;

endpackage

// File: rtl/nes_controller_responder_if.sv
// Controller-port bundle: console strobes and local buttons in, serial data and debug out.
// Handshake: none; nes_latch/nes_pulse are free-running asynchronous levels, outputs are registered.
interface nes_controller_responder_if;
   import nes_pkg::*;

   logic                nes_latch;
   logic                nes_pulse;
   logic [NES_BITS-1:0] buttons;
   logic                nes_data;
   logic                frame_done;
   logic [3:0]          bit_index;
   nes_state_t          state;

   modport master (
      output nes_latch, nes_pulse, buttons,
      input  nes_data, frame_done, bit_index, state
   );

   modport slave (
      input  nes_latch, nes_pulse, buttons,
      output nes_data, frame_done, bit_index, state
   );

endinterface

// File: rtl/nes_sync_edge.sv
// Multi-flop synchroniser for one asynchronous strobe, followed by a
// previous-value flop that yields single-cycle rise and fall pulses.
module nes_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/nes_controller_responder.sv
// NES controller device side: answers console latch/pulse strobes with the local
// button levels, serialised active-low on nes_data, A first.
module nes_controller_responder
   import nes_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 25175
) (
   input logic                        clk,
   input logic                        reset,
   nes_controller_responder_if.slave  bus
);

   localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

   logic latch_level, latch_rise, latch_fall;
   logic pulse_level, pulse_rise, pulse_fall;
   logic unused_pulse;

   nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
      .clk   (clk),
      .reset (reset),
      .din   (bus.nes_latch),
      .level (latch_level),
      .rise  (latch_rise),
      .fall  (latch_fall)
   );

   nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
      .clk   (clk),
      .reset (reset),
      .din   (bus.nes_pulse),
      .level (pulse_level),
      .rise  (pulse_rise),
      .fall  (pulse_fall)
   );

   assign unused_pulse = pulse_level ^ pulse_fall;

   nes_state_t          state_q;
   logic [NES_BITS-1:0] shift_q;
   logic [TW-1:0]       timer_q;
   logic                data_q;
   logic                done_q;
   logic [3:0]          index_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         timer_q <= '0;
         data_q  <= 1'b1;
         done_q  <= 1'b0;
         index_q <= 4'd0;
      end else begin
         done_q <= 1'b0;
         // A new latch outranks everything, including a coincident pulse.
         if (latch_rise) begin
            state_q <= LATCHED;
            shift_q <= bus.buttons;
            data_q  <= ~bus.buttons[BTN_A];
            index_q <= 4'd0;
            timer_q <= '0;
         end else if (state_q != IDLE && timer_q == TIMEOUT_MAX) begin
            state_q <= IDLE;
            data_q  <= 1'b1;
            index_q <= 4'd0;
            timer_q <= '0;
         end else begin
            if (state_q == IDLE || pulse_rise)
               timer_q <= '0;
            else if (timer_q != TIMEOUT_MAX)
               timer_q <= timer_q + 1'b1;

            case (state_q)
               IDLE: data_q <= 1'b1;
               LATCHED: begin
                  shift_q <= bus.buttons;
                  data_q  <= ~bus.buttons[BTN_A];
                  index_q <= 4'd0;
                  if (latch_fall)
                     state_q <= SHIFTING;
               end
               SHIFTING: begin
                  if (pulse_rise && !latch_level) begin
                     shift_q <= {1'b0, shift_q[NES_BITS-1:1]};
                     if (index_q == 4'(NES_BITS - 1)) begin
                        data_q  <= 1'b1;
                        done_q  <= 1'b1;
                        index_q <= 4'(NES_BITS);
                        state_q <= DONE;
                     end else begin
                        data_q  <= ~shift_q[1];
                        index_q <= index_q + 4'd1;
                     end
                  end
               end
               DONE: data_q <= 1'b1;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.nes_data   = data_q;
   assign bus.frame_done = done_q;
   assign bus.bit_index  = index_q;
   assign bus.state      = state_q;

endmodule
